apb_req_arbiter: RTL and testbench

Round-robin arbiter that shares the single user-side command port of the APB master among NUM_REQ requesters. It accepts one command at a time, drives the master's transfer/write_read/addr_in/wdata_in/strb_in inputs until transfer_done, and routes rdata_out/error back to the granted requester as a one-cycle response. It sits between the requester blocks and the APB master, on the same pclk domain and system reset.

---
 rtl/apb_arb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/apb_req_arbiter.sv | 130 +++++++++++++
 tb/tb_apb_req_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types for the APB requester arbiter: FSM state encoding and the grant index type.
package apb_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } arb_state_e;

    localparam int unsigned NumReqDefault = 4;

    typedef logic [$clog2(NumReqDefault)-1:0] grant_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: search starts one past the last grant; the pointer advances only on accept.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NumReqDefault,
    localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]    gnt_idx_o,
    output logic [IdxW-1:0]    last_o
);

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] cand_idx;
    int unsigned     cand;
    logic            found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        // Offset 1..NUM_REQ so the last winner is checked last.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand     = (32'(ptr_q) + i) % NUM_REQ;
            cand_idx = IdxW'(cand);
            if (!found && req_i[cand_idx]) begin
                found            = 1'b1;
                gnt_o[cand_idx]  = 1'b1;
                gnt_idx_o        = cand_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= IdxW'(NUM_REQ - 1);
        end else if (en_i) begin
            ptr_q <= gnt_idx_o;
        end
    end

    assign last_o = ptr_q;

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares the APB master's command port among NUM_REQ requesters, one command in flight at a time,
// and routes the completion back to the owner as a one-cycle response.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NumReqDefault,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned StrbW     = DATA_WIDTH / 8,
    localparam int unsigned IdxW      = $clog2(NUM_REQ)
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*StrbW-1:0]      req_strb,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_error,
    output logic                          transfer,
    output logic                          write_read,
    output logic [ADDR_WIDTH-1:0]         addr_in,
    output logic [DATA_WIDTH-1:0]         wdata_in,
    output logic [StrbW-1:0]              strb_in,
    input  logic [DATA_WIDTH-1:0]         rdata_out,
    input  logic                          transfer_done,
    input  logic                          error,
    output logic                          busy
);

    arb_state_e state_q, state_d;

    logic                  accept;
    logic [NUM_REQ-1:0]    gnt;
    logic [IdxW-1:0]       gnt_idx;
    logic [IdxW-1:0]       owner;

    logic                  cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q,  cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [StrbW-1:0]      cmd_strb_q,  cmd_strb_d;

    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;

    // The arbiter pointer holds the last grant, which is also the owner of the command in flight.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk_i     (pclk),
        .rst_i     (preset),
        .req_i     (req_valid),
        .en_i      (accept),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .last_o    (owner)
    );

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_strb_d  = cmd_strb_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;

        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    accept      = 1'b1;
                    cmd_write_d = req_write[gnt_idx];
                    cmd_addr_d  = req_addr[32'(gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH];
                    cmd_wdata_d = req_wdata[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
                    cmd_strb_d  = req_strb[32'(gnt_idx) * StrbW +: StrbW];
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                if (transfer_done) begin
                    rsp_valid_d[owner] = 1'b1;
                    rsp_rdata_d        = rdata_out;
                    rsp_error_d        = error;
                    state_d            = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= StIdle;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_strb_q  <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_strb_q  <= cmd_strb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign req_ready  = (state_q == StIdle) ? gnt : '0;
    assign transfer   = (state_q == StBusy);
    assign busy       = (state_q == StBusy);
    assign write_read = cmd_write_q;
    assign addr_in    = cmd_addr_q;
    assign wdata_in   = cmd_wdata_q;
    assign strb_in    = cmd_strb_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_error  = rsp_error_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: grant and response scoreboards checked on the falling edge.
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic [N-1:0]  vec;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    logic            pclk;
    logic            preset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_strb;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_error;
    logic            transfer;
    logic            write_read;
    logic [AW-1:0]   addr_in;
    logic [DW-1:0]   wdata_in;
    logic [SW-1:0]   strb_in;
    logic [DW-1:0]   rdata_out;
    logic            transfer_done;
    logic            error;
    logic            busy;

    logic [N-1:0]    gq[$];
    rsp_t            rq[$];
    logic            pw[N];
    logic [AW-1:0]   pa[N];
    logic [DW-1:0]   pd[N];
    logic [SW-1:0]   ps[N];
    logic [DW-1:0]   last_rd;
    int              n_checks;
    int              n_fail;

    apb_req_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .pclk          (pclk),
        .preset        (preset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_strb      (req_strb),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_error     (rsp_error),
        .transfer      (transfer),
        .write_read    (write_read),
        .addr_in       (addr_in),
        .wdata_in      (wdata_in),
        .strb_in       (strb_in),
        .rdata_out     (rdata_out),
        .transfer_done (transfer_done),
        .error         (error),
        .busy          (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Falling-edge sampling of grants and responses against the scoreboards.
    task automatic monitor();
        logic [N-1:0] eg;
        rsp_t         er;
        if (req_ready != '0) begin
            if (gq.size() == 0) begin
                chk("ready_unexpected", 64'(req_ready), 64'(0));
            end else begin
                eg = gq.pop_front();
                chk("grant", 64'(req_ready), 64'(eg));
            end
        end
        if (rsp_valid != '0) begin
            if (rq.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                er = rq.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(er.vec));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(er.data));
                chk("rsp_error", 64'(rsp_error), 64'(er.err));
            end
        end
    endtask

    task automatic cyc();
        @(negedge pclk);
        monitor();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        pw[i] = w;
        pa[i] = a;
        pd[i] = d;
        ps[i] = s;
        req_write[i]           = w;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
        req_strb[i*SW +: SW]   = s;
    endtask

    // One command from requester g: accept, nbusy BUSY cycles, then the response cycle.
    task automatic run_xfer(input int g, input int nbusy, input logic drop,
                            input logic [DW-1:0] rd, input logic er);
        rsp_t r;
        gq.push_back(N'(1 << g));
        cyc();
        if (drop) req_valid[g] = 1'b0;
        for (int k = 1; k <= nbusy; k++) begin
            chk("transfer_busy", 64'(transfer), 64'(1));
            chk("busy_flag", 64'(busy), 64'(1));
            chk("addr_in", 64'(addr_in), 64'(pa[g]));
            if (k == 1) begin
                chk("write_read", 64'(write_read), 64'(pw[g]));
                chk("wdata_in", 64'(wdata_in), 64'(pd[g]));
                chk("strb_in", 64'(strb_in), 64'(ps[g]));
            end
            if (k == nbusy) begin
                transfer_done = 1'b1;
                rdata_out     = rd;
                error         = er;
                r.vec  = N'(1 << g);
                r.data = rd;
                r.err  = er;
                rq.push_back(r);
                last_rd = rd;
            end else begin
                error     = 1'b1;  // must be ignored without transfer_done
                rdata_out = 32'hBAD0_0000 | 32'(k);
            end
            cyc();
            transfer_done = 1'b0;
            error         = 1'b0;
        end
        chk("transfer_gap", 64'(transfer), 64'(0));
    endtask

    task automatic do_reset(input int n);
        preset = 1'b1;
        repeat (n) begin
            @(posedge pclk);
        end
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_transfer", 64'(transfer), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_rsp_error", 64'(rsp_error), 64'(0));
        chk("rst_write_read", 64'(write_read), 64'(0));
        chk("rst_addr_in", 64'(addr_in), 64'(0));
        chk("rst_wdata_in", 64'(wdata_in), 64'(0));
        chk("rst_strb_in", 64'(strb_in), 64'(0));
        preset = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        last_rd       = '0;
        preset        = 1'b1;
        req_valid     = '0;
        req_write     = '0;
        req_addr      = '0;
        req_wdata     = '0;
        req_strb      = '0;
        rdata_out     = '0;
        transfer_done = 1'b0;
        error         = 1'b0;

        do_reset(2);

        // Single write from requester 0, completion after two BUSY cycles.
        set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        req_valid = 4'b0001;
        run_xfer(0, 2, 1'b1, 32'hA5A5_5A5A, 1'b0);
        cyc();

        do_reset(1);

        // All four requesting continuously: strict rotation 0,1,2,3,0,1,2,3.
        for (int i = 0; i < N; i++) begin
            set_req(i, i[0], 32'h100 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'(1 << i));
        end
        req_valid = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            run_xfer(t % N, (t % 3) + 1, 1'b0, 32'hC000_0000 + 32'(t), 1'b0);
        end

        // Read from requester 2 completing with a slave error.
        set_req(2, 1'b0, 32'h200, 32'h0, 4'h0);
        req_valid = 4'b0100;
        run_xfer(2, 2, 1'b1, 32'h1234_5678, 1'b1);
        cyc();

        // Reset in the middle of a transfer: no response, pointer back to requester 0 first.
        set_req(1, 1'b1, 32'h300, 32'h3333_3333, 4'h3);
        req_valid = 4'b0010;
        gq.push_back(4'b0010);
        cyc();
        chk("abort_transfer_before", 64'(transfer), 64'(1));
        req_valid = '0;
        preset    = 1'b1;
        cyc();
        chk("abort_transfer_after", 64'(transfer), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_addr_in", 64'(addr_in), 64'(0));
        chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        preset = 1'b0;
        set_req(0, 1'b1, 32'h400, 32'h4444_4444, 4'hC);
        set_req(1, 1'b0, 32'h410, 32'h0, 4'h0);
        set_req(2, 1'b0, 32'h420, 32'h0, 4'h0);
        set_req(3, 1'b0, 32'h430, 32'h0, 4'h0);
        req_valid = 4'b1111;
        run_xfer(0, 2, 1'b1, 32'h0BAD_F00D, 1'b0);
        req_valid = '0;
        cyc();

        // Requester 3 alone, done in the first BUSY cycle: transfer toggles every cycle.
        set_req(3, 1'b1, 32'h500, 32'h5555_AAAA, 4'h9);
        req_valid = 4'b1000;
        for (int t = 0; t < 3; t++) begin
            run_xfer(3, 1, 1'b0, 32'hD000_0000 + 32'(t), t[0]);
        end
        req_valid = '0;
        cyc();

        // Spurious completion while idle.
        transfer_done = 1'b1;
        error         = 1'b1;
        rdata_out     = 32'hFFFF_FFFF;
        cyc();
        transfer_done = 1'b0;
        error         = 1'b0;
        chk("spurious_busy", 64'(busy), 64'(0));
        chk("spurious_transfer", 64'(transfer), 64'(0));
        cyc();
        chk("spurious_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("spurious_rsp_rdata", 64'(rsp_rdata), 64'(last_rd));

        chk("grant_queue_empty", 64'(gq.size()), 64'(0));
        chk("rsp_queue_empty", 64'(rq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
